radix2_div: RTL and testbench

RADIX2_DIV -- requirements
Module: radix2_div

---
 rtl/radix2_div.sv | 141 ++++++++++++++
 tb/tb_radix2_div.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/radix2_div.sv
// Radix-2 restoring integer divider for a RISC-V style exe stage.
// Handles signed/unsigned and word/full-width ops; div-by-zero and overflow finish in one cycle.
module radix2_div #(
  parameter int XLEN   = 64,
  parameter int W32_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              flush,
  input  logic              div_sign,
  input  logic              div_32,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              ready,
  output logic [2*XLEN-1:0] div_result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q, dsr_q;
  logic            word_q, neg_q_q, neg_r_q;

  // Replace bits above 31 with either bit 31 (sign_en=1) or zeros.
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sign_en);
    logic [XLEN-1:0] r;
    r       = {XLEN{sign_en & v[31]}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand conditioning at the accept edge
  // ---------------------------------------------------------------------------
  logic            word;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_ext, spec_q, spec_r;
  logic            a_neg, b_neg, div_zero, ovf;
  logic            accept, special, load, last;

  assign word    = (W32_EN != 0) && div_32;
  assign a_ext   = word ? ext32(rs1_data, div_sign) : rs1_data;
  assign b_ext   = word ? ext32(rs2_data, div_sign) : rs2_data;
  assign a_neg   = div_sign & a_ext[XLEN-1];
  assign b_neg   = div_sign & b_ext[XLEN-1];
  assign a_mag   = a_neg ? -a_ext : a_ext;
  assign b_mag   = b_neg ? -b_ext : b_ext;
  assign min_ext = word ? ext32({{(XLEN-32){1'b0}}, 32'h8000_0000}, 1'b1)
                        : {1'b1, {(XLEN-1){1'b0}}};

  assign div_zero = (b_ext == '0);
  assign ovf      = div_sign && (b_ext == '1) && (a_ext == min_ext);
  assign spec_q   = div_zero ? '1    : a_ext;
  assign spec_r   = div_zero ? a_ext : '0;

  assign accept  = (state == IDLE) && valid && !flush;
  assign special = accept && (div_zero || ovf);
  assign load    = accept && !special;

  // ---------------------------------------------------------------------------
  // One restoring step: shift in the next dividend bit, subtract if it fits
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nxt, quo_nxt, q_fin, r_fin;
  logic [CW-1:0]   n_last;

  assign trial   = {rem_q, quo_q[XLEN-1]} - {1'b0, dsr_q};
  assign rem_nxt = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
  assign quo_nxt = {quo_q[XLEN-2:0], ~trial[XLEN]};
  assign q_fin   = neg_q_q ? -quo_nxt : quo_nxt;
  assign r_fin   = neg_r_q ? -rem_nxt : rem_nxt;
  assign n_last  = word_q ? CW'(31) : CW'(XLEN - 1);
  assign last    = (state == BUSY) && !flush && (cnt == n_last);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (special) state_nxt = DONE;
                 else if (load) state_nxt = BUSY;
        BUSY:    if (last) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign ready = (state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath and result register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      word_q     <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_result <= '0;
    end else begin
      if (load) begin
        cnt     <= '0;
        rem_q   <= '0;
        quo_q   <= word ? (a_mag << (XLEN - 32)) : a_mag;
        dsr_q   <= b_mag;
        word_q  <= word;
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
      end else if (state == BUSY) begin
        cnt   <= cnt + CW'(1);
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end

      // Word results are sign-extended from bit 31 regardless of signedness.
      if (special)
        div_result <= word ? {ext32(spec_r, 1'b1), ext32(spec_q, 1'b1)} : {spec_r, spec_q};
      else if (last)
        div_result <= word_q ? {ext32(r_fin, 1'b1), ext32(q_fin, 1'b1)} : {r_fin, q_fin};
    end
  end

endmodule

// File: tb/tb_radix2_div.sv
// Directed self-checking bench for radix2_div (XLEN=64, word mode enabled).
// Expected quotients, remainders and latencies are hand-computed constants.
module tb_radix2_div;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid, flush, div_sign, div_32;
  logic [63:0]  rs1_data, rs2_data;
  logic         ready;
  logic [127:0] div_result;

  int passed = 0;
  int total  = 0;
  logic [127:0] last_res;

  radix2_div #(.XLEN(64), .W32_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .flush      (flush),
    .div_sign   (div_sign),
    .div_32     (div_32),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .ready      (ready),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one op, measure cycles from the accept edge to ready, check result and pulse width.
  task automatic run_op(input string tag, input logic s, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er, input int elat);
    int lat;
    @(negedge clk);
    valid = 1'b1; div_sign = s; div_32 = w; rs1_data = a; rs2_data = b;
    @(posedge clk);
    #1 valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 128'(lat), 128'(elat));
    check({tag, "_q"}, 128'(div_result[63:0]), 128'(eq));
    check({tag, "_r"}, 128'(div_result[127:64]), 128'(er));
    last_res = {er, eq};
    @(negedge clk);
    check({tag, "_pulse"}, 128'(ready), 128'(0));
  endtask

  initial begin
    logic saw;
    int   lat;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; div_sign = 1'b0; div_32 = 1'b0;
    rs1_data = '0; rs2_data = '0;
    #12;
    check("reset_ready", 128'(ready), 128'(0));
    check("reset_result", div_result, 128'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("s_m7_2",    1, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("u_div0",    0, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
    run_op("w_s_ovf",   1, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 64'd0, 1);
    run_op("w_u_max",   0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);
    run_op("s_ovf64",   1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64'd0, 1);
    run_op("s_7_m2",    1, 0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
    run_op("u_zero",    0, 0, 64'd0, 64'd5, 64'd0, 64'd0, 65);
    run_op("w_s_m7_2",  1, 1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("w_u_100_7", 0, 1, 64'hDEAD_BEEF_0000_0064, 64'h5555_5555_0000_0007, 64'd14, 64'd2, 33);
    run_op("w_s_div0",  1, 1, 64'h0000_0000_8000_0005, 64'hFFFF_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1);
    run_op("u_big",     0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65);
    run_op("s_m100_m7", 1, 0, -64'sd100, -64'sd7, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65);

    // Flush in the tenth BUSY cycle: no pulse, result register untouched.
    @(negedge clk);
    valid = 1'b1; div_sign = 1'b0; div_32 = 1'b0; rs1_data = 64'd100; rs2_data = 64'd7;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (ready) saw = 1'b1;
    end
    check("flush_no_ready", 128'(saw), 128'(0));
    check("flush_hold", div_result, last_res);
    run_op("after_flush", 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 65);

    // Flush wins over a simultaneous valid in IDLE.
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; rs1_data = 64'd50; rs2_data = 64'd0;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    saw = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (ready) saw = 1'b1;
    end
    check("flush_vs_valid", 128'(saw), 128'(0));

    // Back-to-back with valid held high: 20/3 then 9/4.
    @(negedge clk);
    valid = 1'b1; div_sign = 1'b0; div_32 = 1'b0; rs1_data = 64'd20; rs2_data = 64'd3;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        break;
      end
    end
    check("b2b_1_lat", 128'(lat), 128'(65));
    check("b2b_1_res", div_result, {64'd2, 64'd6});
    rs1_data = 64'd9; rs2_data = 64'd4;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        break;
      end
    end
    valid = 1'b0;
    check("b2b_2_lat", 128'(lat), 128'(66));
    check("b2b_2_res", div_result, {64'd1, 64'd2});

    // Reset mid-operation clears outputs immediately and kills the op.
    @(negedge clk);
    valid = 1'b1; rs1_data = 64'd100; rs2_data = 64'd7;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 128'(ready), 128'(0));
    check("rst_mid_result", div_result, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (ready) saw = 1'b1;
    end
    check("rst_no_ready", 128'(saw), 128'(0));
    run_op("after_rst", 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 65);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
